// File: rtl/chan_display_sequencer.sv
// N-channel display sequencer: manual or auto-rotating selection of one W-bit
// source onto a registered result bus, with a freeze control that holds everything.
module chan_display_sequencer #(
  parameter int N_CH  = 4,
  parameter int W     = 3,
  parameter int DWELL = 8,
  localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic                freeze,
  input  logic [N_CH*W-1:0]   ch_data,
  output logic [W-1:0]        result,
  output logic [SEL_W-1:0]    cur_ch,
  output logic                switched
);

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0]  LAST_CH    = SEL_W'(N_CH - 1);
  localparam logic [DCNT_W-1:0] LAST_DWELL = DCNT_W'(DWELL - 1);

  state_t             state;
  logic [DCNT_W-1:0]  dwell_cnt;
  logic [DCNT_W-1:0]  dwell_base;
  logic               sel_ok;
  logic [W-1:0]       ch_arr [N_CH];

  function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] c);
    return (c == LAST_CH) ? '0 : c + 1'b1;
  endfunction

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      ch_arr[k] = ch_data[k*W +: W];
    end
  end

  // Coming straight from MANUAL the count always restarts, whatever it held.
  assign dwell_base = (state == MANUAL) ? '0 : dwell_cnt;
  assign sel_ok     = (32'(sel) < N_CH);

  // Stage boundary: control state and registered output bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= MANUAL;
      dwell_cnt <= '0;
      cur_ch    <= '0;
      switched  <= 1'b0;
      result    <= '0;
    end else if (freeze) begin
      state    <= HOLD;
      switched <= 1'b0;
    end else begin
      result <= ch_arr[cur_ch];
      if (mode) begin
        state <= AUTO;
        if (dwell_base == LAST_DWELL) begin
          dwell_cnt <= '0;
          cur_ch    <= next_ch(cur_ch);
          switched  <= 1'b1;
        end else begin
          dwell_cnt <= dwell_base + 1'b1;
          switched  <= 1'b0;
        end
      end else begin
        state     <= MANUAL;
        dwell_cnt <= '0;
        if (sel_ok && (sel != cur_ch)) begin
          cur_ch   <= sel;
          switched <= 1'b1;
        end else begin
          switched <= 1'b0;
        end
      end
    end
  end

endmodule
